// File: rtl/bus_arbiter.sv
// Two-master round-robin arbiter serialising CPU and JPEG/loader accesses onto the
// single write-back bus master port, with a registered req/gnt/rvalid handshake.
module bus_arbiter #(
  parameter int unsigned RAM_WORDS   = 32'd411700,
  parameter int unsigned BUTTON_ADDR = 32'd411700
) (
  input  logic        clock,
  input  logic        nreset,
  input  logic        m0_req,
  input  logic [31:0] m0_addr,
  input  logic        m0_write,
  input  logic [31:0] m0_wdata,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  output logic        m0_err,
  input  logic        m1_req,
  input  logic [31:0] m1_addr,
  input  logic        m1_write,
  input  logic [31:0] m1_wdata,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  output logic        m1_err,
  output logic [31:0] bus_addr,
  output logic        bus_write,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  output logic        owner
);

  localparam logic [31:0] RAM_LIM    = 32'(RAM_WORDS);
  localparam logic [31:0] BUTTON_LIM = 32'(BUTTON_ADDR);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  // Only RAM words and the single button word decode; anything else is an error.
  function automatic logic addr_err(input logic [31:0] a);
    return !((a < RAM_LIM) || (a == BUTTON_LIM));
  endfunction

  state_t      state_r;
  logic        ptr_r;
  logic        win_r;
  logic        write_r;
  logic        m0_gnt_r, m1_gnt_r;
  logic        m0_rvalid_r, m1_rvalid_r;
  logic [31:0] m0_rdata_r, m1_rdata_r;
  logic        m0_err_r, m1_err_r;
  logic [31:0] bus_addr_r, bus_wdata_r;
  logic        bus_write_r;
  logic        owner_r;

  logic        any_req_s;
  logic        win_s;
  logic [31:0] sel_addr_s;
  logic [31:0] sel_wdata_s;
  logic        sel_write_s;
  logic        acc_err_s;
  logic [31:0] cap_rdata_s;

  // Arbitration decision and operand selection for the IDLE cycle.
  always_comb begin
    any_req_s   = m0_req | m1_req;
    win_s       = 1'b0;
    sel_addr_s  = 32'd0;
    sel_wdata_s = 32'd0;
    sel_write_s = 1'b0;
    if (m0_req && m1_req) begin
      win_s = ptr_r;
    end else begin
      win_s = m1_req;
    end
    if (win_s) begin
      sel_addr_s  = m1_addr;
      sel_wdata_s = m1_wdata;
      sel_write_s = m1_write;
    end else begin
      sel_addr_s  = m0_addr;
      sel_wdata_s = m0_wdata;
      sel_write_s = m0_write;
    end
    acc_err_s = addr_err(bus_addr_r);
    if (write_r || acc_err_s) begin
      cap_rdata_s = 32'd0;
    end else begin
      cap_rdata_s = bus_rdata;
    end
  end

  // Transaction FSM; every output is a register updated here.
  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state_r     <= IDLE;
      ptr_r       <= 1'b0;
      win_r       <= 1'b0;
      write_r     <= 1'b0;
      m0_gnt_r    <= 1'b0;
      m1_gnt_r    <= 1'b0;
      m0_rvalid_r <= 1'b0;
      m1_rvalid_r <= 1'b0;
      m0_rdata_r  <= 32'd0;
      m1_rdata_r  <= 32'd0;
      m0_err_r    <= 1'b0;
      m1_err_r    <= 1'b0;
      bus_addr_r  <= 32'd0;
      bus_wdata_r <= 32'd0;
      bus_write_r <= 1'b0;
      owner_r     <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (any_req_s) begin
            state_r     <= ACCESS;
            win_r       <= win_s;
            write_r     <= sel_write_s;
            owner_r     <= win_s;
            m0_gnt_r    <= ~win_s;
            m1_gnt_r    <= win_s;
            bus_addr_r  <= sel_addr_s;
            bus_wdata_r <= sel_wdata_s;
            bus_write_r <= sel_write_s & ~addr_err(sel_addr_s);
          end else begin
            state_r <= IDLE;
          end
        end
        ACCESS: begin
          state_r     <= RESP;
          m0_gnt_r    <= 1'b0;
          m1_gnt_r    <= 1'b0;
          bus_addr_r  <= 32'd0;
          bus_wdata_r <= 32'd0;
          bus_write_r <= 1'b0;
          if (win_r) begin
            m1_rvalid_r <= 1'b1;
            m1_rdata_r  <= cap_rdata_s;
            m1_err_r    <= acc_err_s;
          end else begin
            m0_rvalid_r <= 1'b1;
            m0_rdata_r  <= cap_rdata_s;
            m0_err_r    <= acc_err_s;
          end
        end
        RESP: begin
          state_r     <= IDLE;
          m0_rvalid_r <= 1'b0;
          m1_rvalid_r <= 1'b0;
          owner_r     <= 1'b0;
          ptr_r       <= ~win_r;
        end
        default: begin
          state_r     <= IDLE;
          m0_gnt_r    <= 1'b0;
          m1_gnt_r    <= 1'b0;
          m0_rvalid_r <= 1'b0;
          m1_rvalid_r <= 1'b0;
          bus_addr_r  <= 32'd0;
          bus_wdata_r <= 32'd0;
          bus_write_r <= 1'b0;
          owner_r     <= 1'b0;
        end
      endcase
    end
  end

  assign m0_gnt    = m0_gnt_r;
  assign m1_gnt    = m1_gnt_r;
  assign m0_rvalid = m0_rvalid_r;
  assign m1_rvalid = m1_rvalid_r;
  assign m0_rdata  = m0_rdata_r;
  assign m1_rdata  = m1_rdata_r;
  assign m0_err    = m0_err_r;
  assign m1_err    = m1_err_r;
  assign bus_addr  = bus_addr_r;
  assign bus_write = bus_write_r;
  assign bus_wdata = bus_wdata_r;
  assign owner     = owner_r;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed self-checking bench for bus_arbiter: handshake timing, decode errors,
// round-robin order, async reset and back-to-back requests.
module tb_bus_arbiter;

  logic        clock;
  logic        nreset;
  logic        m0_req, m0_write, m1_req, m1_write;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic        bus_write, owner;

  int checks;
  int failures;

  bus_arbiter dut (
    .clock(clock), .nreset(nreset),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_write(m0_write), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_write(m1_write), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .bus_addr(bus_addr), .bus_write(bus_write), .bus_wdata(bus_wdata),
    .bus_rdata(bus_rdata), .owner(owner)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    nreset = 1'b0;
    m0_req = 1'b0; m0_write = 1'b0; m0_addr = 32'd0; m0_wdata = 32'd0;
    m1_req = 1'b0; m1_write = 1'b0; m1_addr = 32'd0; m1_wdata = 32'd0;
    bus_rdata = 32'd0;
    #3;
    checks++; if (m0_gnt !== 1'b0 || m1_gnt !== 1'b0) begin failures++; $display("FAIL rst_gnt got=%b%b exp=00", m0_gnt, m1_gnt); end
    checks++; if (m0_rvalid !== 1'b0 || m1_rvalid !== 1'b0) begin failures++; $display("FAIL rst_rvalid got=%b%b exp=00", m0_rvalid, m1_rvalid); end
    checks++; if (bus_addr !== 32'd0 || bus_write !== 1'b0 || bus_wdata !== 32'd0) begin failures++; $display("FAIL rst_bus got=%h/%b/%h exp=0", bus_addr, bus_write, bus_wdata); end
    checks++; if (m0_rdata !== 32'd0 || m1_rdata !== 32'd0 || owner !== 1'b0) begin failures++; $display("FAIL rst_data got=%h/%h/%b exp=0", m0_rdata, m1_rdata, owner); end
    #9;
    nreset = 1'b1;
    tick();
    checks++; if (m0_gnt !== 1'b0 || bus_write !== 1'b0) begin failures++; $display("FAIL idle_noreq got=%b/%b exp=0/0", m0_gnt, bus_write); end
  endtask

  task automatic test_m0_write();
    m0_req = 1'b1; m0_addr = 32'd100; m0_write = 1'b1; m0_wdata = 32'hDEADBEEF;
    tick();
    m0_req = 1'b0;
    checks++; if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0) begin failures++; $display("FAIL m0w_gnt got=%b%b exp=10", m0_gnt, m1_gnt); end
    checks++; if (bus_write !== 1'b1 || bus_addr !== 32'd100 || bus_wdata !== 32'hDEADBEEF) begin failures++; $display("FAIL m0w_bus got=%b/%0d/%h exp=1/100/deadbeef", bus_write, bus_addr, bus_wdata); end
    checks++; if (owner !== 1'b0 || m0_rvalid !== 1'b0) begin failures++; $display("FAIL m0w_acc got=owner%b rv%b exp=0/0", owner, m0_rvalid); end
    tick();
    checks++; if (m0_rvalid !== 1'b1 || m0_err !== 1'b0 || m0_rdata !== 32'd0) begin failures++; $display("FAIL m0w_resp got=%b/%b/%h exp=1/0/0", m0_rvalid, m0_err, m0_rdata); end
    checks++; if (bus_write !== 1'b0 || m0_gnt !== 1'b0 || bus_addr !== 32'd0) begin failures++; $display("FAIL m0w_busoff got=%b/%b/%0d exp=0/0/0", bus_write, m0_gnt, bus_addr); end
    tick();
    checks++; if (m0_rvalid !== 1'b0 || bus_write !== 1'b0) begin failures++; $display("FAIL m0w_idle got=%b/%b exp=0/0", m0_rvalid, bus_write); end
  endtask

  task automatic test_m1_read();
    bus_rdata = 32'h00000005;
    m1_req = 1'b1; m1_addr = 32'd411700; m1_write = 1'b0; m1_wdata = 32'h11111111;
    tick();
    m1_req = 1'b0;
    checks++; if (m1_gnt !== 1'b1 || m0_gnt !== 1'b0 || owner !== 1'b1) begin failures++; $display("FAIL m1r_gnt got=%b%b own%b exp=01/1", m0_gnt, m1_gnt, owner); end
    checks++; if (bus_addr !== 32'd411700 || bus_write !== 1'b0) begin failures++; $display("FAIL m1r_bus got=%0d/%b exp=411700/0", bus_addr, bus_write); end
    tick();
    checks++; if (m1_rvalid !== 1'b1 || m1_rdata !== 32'd5 || m1_err !== 1'b0 || owner !== 1'b1) begin failures++; $display("FAIL m1r_resp got=%b/%h/%b/%b exp=1/5/0/1", m1_rvalid, m1_rdata, m1_err, owner); end
    checks++; if (m0_rvalid !== 1'b0 || m0_rdata !== 32'd0 || m0_err !== 1'b0) begin failures++; $display("FAIL m1r_m0quiet got=%b/%h/%b exp=0/0/0", m0_rvalid, m0_rdata, m0_err); end
    tick();
    checks++; if (m1_rvalid !== 1'b0 || owner !== 1'b0 || m1_rdata !== 32'd5) begin failures++; $display("FAIL m1r_hold got=%b/%b/%h exp=0/0/5", m1_rvalid, owner, m1_rdata); end
  endtask

  task automatic test_fairness();
    logic exp_w;
    bus_rdata = 32'h0000ABCD;
    m0_req = 1'b1; m0_addr = 32'd10; m0_write = 1'b0;
    m1_req = 1'b1; m1_addr = 32'd20; m1_write = 1'b0;
    for (int i = 0; i < 4; i++) begin
      exp_w = i[0];
      tick();
      if (i == 3) begin
        m0_req = 1'b0; m1_req = 1'b0;
      end
      checks++; if (m0_gnt !== ~exp_w || m1_gnt !== exp_w || owner !== exp_w) begin failures++; $display("FAIL rr_gnt%0d got=%b%b own%b exp_owner=%b", i, m0_gnt, m1_gnt, owner, exp_w); end
      checks++; if (bus_addr !== (exp_w ? 32'd20 : 32'd10)) begin failures++; $display("FAIL rr_addr%0d got=%0d exp=%0d", i, bus_addr, exp_w ? 20 : 10); end
      tick();
      checks++; if (m0_rvalid !== ~exp_w || m1_rvalid !== exp_w) begin failures++; $display("FAIL rr_rv%0d got=%b%b exp_owner=%b", i, m0_rvalid, m1_rvalid, exp_w); end
      tick();
    end
    checks++; if (m0_gnt !== 1'b0 || m1_gnt !== 1'b0) begin failures++; $display("FAIL rr_end got=%b%b exp=00", m0_gnt, m1_gnt); end
  endtask

  task automatic test_error();
    bus_rdata = 32'h00001234;
    m0_req = 1'b1; m0_addr = 32'd411701; m0_write = 1'b1; m0_wdata = 32'hCAFEF00D;
    tick();
    m0_req = 1'b0;
    checks++; if (m0_gnt !== 1'b1 || bus_write !== 1'b0 || bus_addr !== 32'd411701) begin failures++; $display("FAIL err_w_bus got=%b/%b/%0d exp=1/0/411701", m0_gnt, bus_write, bus_addr); end
    tick();
    checks++; if (m0_rvalid !== 1'b1 || m0_err !== 1'b1 || m0_rdata !== 32'd0) begin failures++; $display("FAIL err_w_resp got=%b/%b/%h exp=1/1/0", m0_rvalid, m0_err, m0_rdata); end
    tick();
    bus_rdata = 32'hA5A5A5A5;
    m1_req = 1'b1; m1_addr = 32'hFFFFFFFF; m1_write = 1'b0;
    tick();
    m1_req = 1'b0;
    checks++; if (m1_gnt !== 1'b1 || bus_addr !== 32'hFFFFFFFF || bus_write !== 1'b0) begin failures++; $display("FAIL err_max_bus got=%b/%h/%b exp=1/ffffffff/0", m1_gnt, bus_addr, bus_write); end
    tick();
    checks++; if (m1_rvalid !== 1'b1 || m1_err !== 1'b1 || m1_rdata !== 32'd0) begin failures++; $display("FAIL err_max_resp got=%b/%b/%h exp=1/1/0", m1_rvalid, m1_err, m1_rdata); end
    tick();
    m0_req = 1'b1; m0_addr = 32'd411699; m0_write = 1'b1; m0_wdata = 32'h0BADCAFE;
    tick();
    m0_req = 1'b0;
    checks++; if (bus_write !== 1'b1 || bus_addr !== 32'd411699) begin failures++; $display("FAIL ram_top_bus got=%b/%0d exp=1/411699", bus_write, bus_addr); end
    tick();
    checks++; if (m0_rvalid !== 1'b1 || m0_err !== 1'b0 || m0_rdata !== 32'd0) begin failures++; $display("FAIL ram_top_resp got=%b/%b/%h exp=1/0/0", m0_rvalid, m0_err, m0_rdata); end
    tick();
    bus_rdata = 32'h00001234;
    m0_req = 1'b1; m0_addr = 32'd411699; m0_write = 1'b0;
    tick();
    m0_req = 1'b0;
    tick();
    checks++; if (m0_rvalid !== 1'b1 || m0_err !== 1'b0 || m0_rdata !== 32'h00001234) begin failures++; $display("FAIL ram_rd_resp got=%b/%b/%h exp=1/0/1234", m0_rvalid, m0_err, m0_rdata); end
    tick();
  endtask

  task automatic test_async_reset();
    m1_req = 1'b1; m1_addr = 32'd50; m1_write = 1'b1; m1_wdata = 32'h55AA55AA;
    tick();
    m1_req = 1'b0;
    checks++; if (m1_gnt !== 1'b1 || bus_write !== 1'b1 || owner !== 1'b1) begin failures++; $display("FAIL ar_pre got=%b/%b/%b exp=1/1/1", m1_gnt, bus_write, owner); end
    #2;
    nreset = 1'b0;
    #1;
    checks++; if (bus_write !== 1'b0 || m1_gnt !== 1'b0 || owner !== 1'b0 || bus_addr !== 32'd0) begin failures++; $display("FAIL ar_drop got=%b/%b/%b/%0d exp=0/0/0/0", bus_write, m1_gnt, owner, bus_addr); end
    checks++; if (m0_rdata !== 32'd0) begin failures++; $display("FAIL ar_rdata got=%h exp=0", m0_rdata); end
    m0_req = 1'b1; m0_addr = 32'd7; m0_write = 1'b0;
    m1_req = 1'b1; m1_addr = 32'd8; m1_write = 1'b0;
    #2;
    nreset = 1'b1;
    tick();
    m0_req = 1'b0; m1_req = 1'b0;
    checks++; if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0 || bus_addr !== 32'd7) begin failures++; $display("FAIL ar_ptr got=%b%b/%0d exp=10/7", m0_gnt, m1_gnt, bus_addr); end
    tick();
    tick();
  endtask

  task automatic test_back_to_back();
    bus_rdata = 32'h00000007;
    m0_req = 1'b1; m0_addr = 32'd100; m0_write = 1'b0;
    tick();
    m0_addr = 32'd200;
    checks++; if (m0_gnt !== 1'b1 || bus_addr !== 32'd100) begin failures++; $display("FAIL b2b_g1 got=%b/%0d exp=1/100", m0_gnt, bus_addr); end
    tick();
    checks++; if (m0_gnt !== 1'b0 || m0_rvalid !== 1'b1 || m0_rdata !== 32'd7) begin failures++; $display("FAIL b2b_resp got=%b/%b/%h exp=0/1/7", m0_gnt, m0_rvalid, m0_rdata); end
    tick();
    checks++; if (m0_gnt !== 1'b0 || m0_rvalid !== 1'b0) begin failures++; $display("FAIL b2b_idle got=%b/%b exp=0/0", m0_gnt, m0_rvalid); end
    tick();
    m0_req = 1'b0;
    checks++; if (m0_gnt !== 1'b1 || bus_addr !== 32'd200 || m1_gnt !== 1'b0) begin failures++; $display("FAIL b2b_g2 got=%b/%0d/%b exp=1/200/0", m0_gnt, bus_addr, m1_gnt); end
    tick();
    tick();
    tick();
    checks++; if (m0_gnt !== 1'b0 || owner !== 1'b0) begin failures++; $display("FAIL b2b_end got=%b/%b exp=0/0", m0_gnt, owner); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_m0_write();
    test_m1_read();
    test_fairness();
    test_error();
    test_async_reset();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Two-master arbiter for the SoC data bus: master 0 is the CPU load/store port, master 1 is the JPEG output / loader engine.
- Serialises their accesses onto the single master port of the write-back bus. That port fans out to RAM (words 0..411699) and the button interface (411700).
- Provides a registered request/grant/response handshake, round-robin fairness, and out-of-range address detection.

Parameters:
- RAM_WORDS, 411700, number of RAM word addresses; RAM decodes 0..RAM_WORDS-1.
- BUTTON_ADDR, 411700, single button-interface address; any address > BUTTON_ADDR is an error.

Ports:
- clock  in  1  system clock, rising edge.
- nreset  in  1  asynchronous active-low reset.
- m0_req  in  1  master 0 request, level.
- m0_addr  in  32  master 0 word address.
- m0_write  in  1  master 0 write (1) / read (0).
- m0_wdata  in  32  master 0 write data.
- m0_gnt  out  1  master 0 request accepted (ACCESS cycle).
- m0_rvalid  out  1  master 0 transaction complete, one-cycle pulse.
- m0_rdata  out  32  master 0 read data, valid with m0_rvalid.
- m0_err  out  1  master 0 address error, valid with m0_rvalid.
- m1_req, m1_addr, m1_write, m1_wdata, m1_gnt, m1_rvalid, m1_rdata, m1_err: same widths and meaning for master 1.
- bus_addr  out  32  address to bus master port.
- bus_write  out  1  write strobe to bus master port.
- bus_wdata  out  32  write data to bus master port.
- bus_rdata  in  32  read data from bus master port (combinational from slave).
- owner  out  1  index of the master owning the current transaction; 0 when idle.

Behaviour:
- Reset (async, nreset=0):
  - state=IDLE, priority pointer ptr=0.
  - All outputs 0; latched addr/write/wdata/rdata registers 0.
  - Effective immediately, including mid-transaction. A write in ACCESS is aborted, bus_write drops at once, and the master must reissue.
- FSM states IDLE, ACCESS, RESP. One transaction takes 3 cycles; at most one is in flight.
- IDLE:
  - If no req, stay.
  - If exactly one req is high, that master wins.
  - If both are high, master ptr wins.
  - On the clock edge, latch the winner's addr/write/wdata and the winner index, then go to ACCESS.
- ACCESS:
  - mX_gnt=1 for the winner only.
  - bus_addr/bus_wdata come from the latch; bus_write=latched write AND address in range.
  - On the edge, capture bus_rdata into the winner's rdata register. For a write or error, capture 0 instead.
  - Set err = latched addr > BUTTON_ADDR, then go to RESP.
- RESP:
  - mX_rvalid=1 for the winner, with rdata/err stable. Writes also get rvalid (completion).
  - Bus outputs are 0.
  - On the edge, ptr <= ~winner, then go to IDLE.
- Bus outputs (addr, write, wdata) are 0 outside ACCESS. owner is valid during ACCESS and RESP.
- mX_rdata and mX_err hold their value until that master's next RESP. Master-side rvalid, gnt and err are only ever asserted for the current winner.
- Request rule:
  - A master holds req and its operands stable from assertion until it sees gnt.
  - A req still high in IDLE is a new transaction. Masters drop req in the cycle after gnt unless issuing back-to-back.
  - req changes during ACCESS/RESP are ignored.
- Error access (addr > BUTTON_ADDR): bus_write forced 0, bus_addr still driven, rdata=0, err=1. The slaves are never written.
- Boundary addresses:
  - 411699 is RAM.
  - 411700 is the button interface.
  - 411701 and 0xFFFFFFFF are errors.
  - Comparison is unsigned 32-bit.
- Fairness: with both masters requesting continuously, grants alternate 0,1,0,1 starting from ptr. Worst-case wait for a requester is 3 cycles plus its own transaction.

Test Plan:
- Reset then m0 write addr=100 wdata=0xDEADBEEF: m0_gnt at cycle 2 with bus_write=1, bus_addr=100. m0_rvalid at cycle 3 with err=0. bus_write=0 in every other cycle.
- m1 read addr=411700 with bus_rdata=0x00000005 during ACCESS: m1_rvalid with m1_rdata=5, err=0, owner=1 during ACCESS/RESP. m0 outputs stay 0.
- m0 and m1 both request continuously from reset: grant order m0,m1,m0,m1. Each rvalid is 3 cycles apart; ptr toggles after each RESP.
- m0 write addr=411701: bus_write stays 0, m0_rvalid=1 with m0_err=1 and m0_rdata=0. Repeat at addr=411699: err=0, bus_write=1.
- Assert nreset=0 asynchronously mid-ACCESS of an m1 write: bus_write, m1_gnt and owner drop within the same cycle. After release, state is IDLE and ptr=0; a simultaneous request then grants m0 first.
- m0 holds req high through RESP with new addr=200: second transaction starts in the IDLE following RESP. Its gnt arrives 3 cycles after the first gnt and bus_addr=200.
